// File: rtl/bp_be_rf_wb_arbiter.sv
// Register-file writeback arbiter with an issue-side scoreboard.
// One regfile write per cycle is granted in the order cfg > wb0 > round-robin(wb1, wb2).
// The winner is registered onto the rd_* port one cycle after the transfer.
// busy_o marks registers with an outstanding writeback so issue can stall on RAW/WAW hazards.
//
// Handshake: a writeback source holds wbN_v_i with stable addr/data until it sees
// wbN_ready_o; a transfer happens on the rising edge where both are high. wbN_ready_o is
// combinational and is only ever high for the granted source. The cfg bus has no ready:
// it always wins. Issue is accepted on an edge where issue_v_i and issue_ready_o are both
// high, and issue_ready_o never looks at issue_v_i.
module bp_be_rf_wb_arbiter #(
  parameter int reg_addr_width_p = 5,
  parameter int dword_width_p    = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          cfg_w_v_i,
  input  logic [reg_addr_width_p-1:0]   cfg_addr_i,
  input  logic [dword_width_p-1:0]      cfg_data_i,
  input  logic                          wb0_v_i,
  input  logic [reg_addr_width_p-1:0]   wb0_addr_i,
  input  logic [dword_width_p-1:0]      wb0_data_i,
  output logic                          wb0_ready_o,
  input  logic                          wb1_v_i,
  input  logic [reg_addr_width_p-1:0]   wb1_addr_i,
  input  logic [dword_width_p-1:0]      wb1_data_i,
  output logic                          wb1_ready_o,
  input  logic                          wb2_v_i,
  input  logic [reg_addr_width_p-1:0]   wb2_addr_i,
  input  logic [dword_width_p-1:0]      wb2_data_i,
  output logic                          wb2_ready_o,
  input  logic                          issue_v_i,
  input  logic                          issue_rd_w_v_i,
  input  logic [reg_addr_width_p-1:0]   issue_rd_addr_i,
  input  logic [reg_addr_width_p-1:0]   issue_rs1_addr_i,
  input  logic [reg_addr_width_p-1:0]   issue_rs2_addr_i,
  output logic                          issue_ready_o,
  output logic                          rd_w_v_o,
  output logic [reg_addr_width_p-1:0]   rd_addr_o,
  output logic [dword_width_p-1:0]      rd_data_o,
  output logic [2**reg_addr_width_p-1:0] busy_o
);

  localparam int num_regs_lp = 2**reg_addr_width_p;

  // rr_q = 0 favours wb1, rr_q = 1 favours wb2
  logic                         rr_q;
  logic [num_regs_lp-1:0]       busy_q;
  logic [num_regs_lp-1:0]       busy_n;
  logic [num_regs_lp-1:0]       set_mask;
  logic [num_regs_lp-1:0]       clr_mask;
  logic                         rd_w_v_q;
  logic [reg_addr_width_p-1:0]  rd_addr_q;
  logic [dword_width_p-1:0]     rd_data_q;

  logic                         wb0_xfer, wb1_xfer, wb2_xfer, wb_xfer;
  logic [reg_addr_width_p-1:0]  wb_addr;
  logic [dword_width_p-1:0]     wb_data;
  logic                         win_v;
  logic [reg_addr_width_p-1:0]  win_addr;
  logic [dword_width_p-1:0]     win_data;
  logic                         issue_accept;

  // Fixed priority for cfg/wb0, pointer only breaks a wb1/wb2 tie
  assign wb0_ready_o = ~cfg_w_v_i & wb0_v_i;
  assign wb1_ready_o = ~cfg_w_v_i & ~wb0_v_i & wb1_v_i & (~wb2_v_i | ~rr_q);
  assign wb2_ready_o = ~cfg_w_v_i & ~wb0_v_i & wb2_v_i & (~wb1_v_i | rr_q);

  assign wb0_xfer = wb0_v_i & wb0_ready_o;
  assign wb1_xfer = wb1_v_i & wb1_ready_o;
  assign wb2_xfer = wb2_v_i & wb2_ready_o;
  assign wb_xfer  = wb0_xfer | wb1_xfer | wb2_xfer;

  // Hazard check sees only registered busy bits; busy_q[0] is always 0
  assign issue_ready_o = ~(busy_q[issue_rs1_addr_i] | busy_q[issue_rs2_addr_i]
                         | (issue_rd_w_v_i & busy_q[issue_rd_addr_i]));
  assign issue_accept  = issue_v_i & issue_ready_o;

  // Select the writeback source that won this cycle, then fold in cfg
  always_comb begin
    wb_addr  = wb0_addr_i;
    wb_data  = wb0_data_i;
    if (wb1_xfer) begin
      wb_addr = wb1_addr_i;
      wb_data = wb1_data_i;
    end else if (wb2_xfer) begin
      wb_addr = wb2_addr_i;
      wb_data = wb2_data_i;
    end
    win_v    = cfg_w_v_i | wb_xfer;
    win_addr = cfg_w_v_i ? cfg_addr_i : wb_addr;
    win_data = cfg_w_v_i ? cfg_data_i : wb_data;
  end

  // Scoreboard next state: set on issue, clear on pipe writeback, set wins a collision
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_accept && issue_rd_w_v_i) set_mask[issue_rd_addr_i] = 1'b1;
    if (wb_xfer)                        clr_mask[wb_addr]         = 1'b1;
    busy_n    = (busy_q & ~clr_mask) | set_mask;
    busy_n[0] = 1'b0;
  end

  // State registers: scoreboard, round-robin pointer and the registered write port
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_q    <= '0;
      rr_q      <= 1'b0;
      rd_w_v_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      busy_q   <= busy_n;
      if (wb1_xfer)      rr_q <= 1'b1;
      else if (wb2_xfer) rr_q <= 1'b0;
      rd_w_v_q <= win_v & (win_addr != '0);
      if (win_v) begin
        rd_addr_q <= win_addr;
        rd_data_q <= win_data;
      end
    end
  end

  assign rd_w_v_o  = rd_w_v_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
  assign busy_o    = busy_q;

`ifndef SYNTHESIS
  // A writeback to a register nobody marked busy means issue and writeback disagree
  always_ff @(posedge clk_i) begin
    if (reset_n_i && wb_xfer && (wb_addr != '0))
      assert (busy_q[wb_addr])
      else $error("writeback to x%0d which is not busy", wb_addr);
  end
`endif

endmodule

// File: tb/tb_bp_be_rf_wb_arbiter.sv
// Directed bench for the writeback arbiter and scoreboard.
module tb_bp_be_rf_wb_arbiter;

  localparam int A = 5;
  localparam int D = 64;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          cfg_w_v_i;
  logic [A-1:0]  cfg_addr_i;
  logic [D-1:0]  cfg_data_i;
  logic          wb0_v_i, wb1_v_i, wb2_v_i;
  logic [A-1:0]  wb0_addr_i, wb1_addr_i, wb2_addr_i;
  logic [D-1:0]  wb0_data_i, wb1_data_i, wb2_data_i;
  logic          wb0_ready_o, wb1_ready_o, wb2_ready_o;
  logic          issue_v_i, issue_rd_w_v_i;
  logic [A-1:0]  issue_rd_addr_i, issue_rs1_addr_i, issue_rs2_addr_i;
  logic          issue_ready_o;
  logic          rd_w_v_o;
  logic [A-1:0]  rd_addr_o;
  logic [D-1:0]  rd_data_o;
  logic [31:0]   busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  bp_be_rf_wb_arbiter #(.reg_addr_width_p(A), .dword_width_p(D)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cfg_w_v_i(cfg_w_v_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .wb0_v_i(wb0_v_i), .wb0_addr_i(wb0_addr_i), .wb0_data_i(wb0_data_i), .wb0_ready_o(wb0_ready_o),
    .wb1_v_i(wb1_v_i), .wb1_addr_i(wb1_addr_i), .wb1_data_i(wb1_data_i), .wb1_ready_o(wb1_ready_o),
    .wb2_v_i(wb2_v_i), .wb2_addr_i(wb2_addr_i), .wb2_data_i(wb2_data_i), .wb2_ready_o(wb2_ready_o),
    .issue_v_i(issue_v_i), .issue_rd_w_v_i(issue_rd_w_v_i), .issue_rd_addr_i(issue_rd_addr_i),
    .issue_rs1_addr_i(issue_rs1_addr_i), .issue_rs2_addr_i(issue_rs2_addr_i),
    .issue_ready_o(issue_ready_o),
    .rd_w_v_o(rd_w_v_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .busy_o(busy_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Advance to 1 time unit past the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_w_v_i = 0; cfg_addr_i = '0; cfg_data_i = '0;
    wb0_v_i = 0; wb0_addr_i = '0; wb0_data_i = '0;
    wb1_v_i = 0; wb1_addr_i = '0; wb1_data_i = '0;
    wb2_v_i = 0; wb2_addr_i = '0; wb2_data_i = '0;
    issue_v_i = 0; issue_rd_w_v_i = 0;
    issue_rd_addr_i = '0; issue_rs1_addr_i = '0; issue_rs2_addr_i = '0;
  endtask

  task automatic apply_reset();
    reset_n_i = 0;
    #1;
    repeat (2) tick();
    reset_n_i = 1;
  endtask

  // Mark a destination register busy through an accepted issue
  task automatic issue_rd(input logic [A-1:0] rd);
    issue_v_i = 1; issue_rd_w_v_i = 1; issue_rd_addr_i = rd;
    tick();
    issue_v_i = 0; issue_rd_w_v_i = 0; issue_rd_addr_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n_i = 0;
    #1;
    tests_run++; if (busy_o !== 32'h0) begin tests_failed++; $display("FAIL reset_busy: got %h want 0", busy_o); end
    tests_run++; if (rd_w_v_o !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_w_v: got %b want 0", rd_w_v_o); end
    tests_run++; if (rd_addr_o !== 5'd0 || rd_data_o !== 64'd0) begin tests_failed++; $display("FAIL reset_rd_port: got %0d/%h want 0/0", rd_addr_o, rd_data_o); end
    tests_run++; if (issue_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready_o); end
    repeat (2) tick();
    reset_n_i = 1;
    tick();
    tests_run++; if (rd_w_v_o !== 1'b0) begin tests_failed++; $display("FAIL reset_release_no_write: got %b want 0", rd_w_v_o); end
  endtask

  task automatic test_scoreboard();
    issue_v_i = 1; issue_rd_w_v_i = 1; issue_rd_addr_i = 5;
    #1;
    tests_run++; if (issue_ready_o !== 1'b1) begin tests_failed++; $display("FAIL sb_issue_ready: got %b want 1", issue_ready_o); end
    tick();
    issue_v_i = 0; issue_rd_w_v_i = 0; issue_rd_addr_i = 0; issue_rs1_addr_i = 5;
    #1;
    tests_run++; if (busy_o !== 32'h0000_0020) begin tests_failed++; $display("FAIL sb_busy_set: got %h want 00000020", busy_o); end
    tests_run++; if (issue_ready_o !== 1'b0) begin tests_failed++; $display("FAIL sb_rs1_hazard: got %b want 0", issue_ready_o); end
    issue_rs1_addr_i = 0; issue_rs2_addr_i = 5;
    #1;
    tests_run++; if (issue_ready_o !== 1'b0) begin tests_failed++; $display("FAIL sb_rs2_hazard: got %b want 0", issue_ready_o); end
    issue_rs2_addr_i = 0; issue_rd_addr_i = 5; issue_rd_w_v_i = 1;
    #1;
    tests_run++; if (issue_ready_o !== 1'b0) begin tests_failed++; $display("FAIL sb_rd_hazard: got %b want 0", issue_ready_o); end
    issue_rd_w_v_i = 0;
    #1;
    tests_run++; if (issue_ready_o !== 1'b1) begin tests_failed++; $display("FAIL sb_rd_no_write: got %b want 1", issue_ready_o); end
    issue_rd_addr_i = 0; issue_rs1_addr_i = 5;
    wb1_v_i = 1; wb1_addr_i = 5; wb1_data_i = 64'h55;
    #1;
    tests_run++; if (wb1_ready_o !== 1'b1) begin tests_failed++; $display("FAIL sb_wb1_ready: got %b want 1", wb1_ready_o); end
    tests_run++; if (issue_ready_o !== 1'b0) begin tests_failed++; $display("FAIL sb_same_cycle_blocked: got %b want 0", issue_ready_o); end
    tick();
    wb1_v_i = 0;
    #1;
    tests_run++; if (issue_ready_o !== 1'b1) begin tests_failed++; $display("FAIL sb_unblock: got %b want 1", issue_ready_o); end
    tests_run++; if (busy_o !== 32'h0) begin tests_failed++; $display("FAIL sb_busy_clear: got %h want 0", busy_o); end
    tests_run++; if (rd_w_v_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_data_o !== 64'h55) begin tests_failed++; $display("FAIL sb_rd_port: got %b/%0d/%h want 1/5/55", rd_w_v_o, rd_addr_o, rd_data_o); end
    issue_rs1_addr_i = 0;
  endtask

  task automatic test_priority();
    apply_reset();
    issue_rd(3); issue_rd(4); issue_rd(6);
    wb0_v_i = 1; wb0_addr_i = 3; wb0_data_i = 64'h33;
    wb1_v_i = 1; wb1_addr_i = 4; wb1_data_i = 64'h44;
    wb2_v_i = 1; wb2_addr_i = 6; wb2_data_i = 64'h66;
    #1;
    tests_run++; if ({wb0_ready_o, wb1_ready_o, wb2_ready_o} !== 3'b100) begin tests_failed++; $display("FAIL prio_grant_wb0: got %b want 100", {wb0_ready_o, wb1_ready_o, wb2_ready_o}); end
    tick();
    wb0_v_i = 0;
    #1;
    tests_run++; if (rd_w_v_o !== 1'b1 || rd_addr_o !== 5'd3 || rd_data_o !== 64'h33) begin tests_failed++; $display("FAIL prio_rd_t1: got %b/%0d/%h want 1/3/33", rd_w_v_o, rd_addr_o, rd_data_o); end
    tests_run++; if ({wb1_ready_o, wb2_ready_o} !== 2'b10) begin tests_failed++; $display("FAIL prio_grant_wb1: got %b want 10", {wb1_ready_o, wb2_ready_o}); end
    tick();
    wb1_v_i = 0;
    #1;
    tests_run++; if (rd_w_v_o !== 1'b1 || rd_addr_o !== 5'd4 || rd_data_o !== 64'h44) begin tests_failed++; $display("FAIL prio_rd_t2: got %b/%0d/%h want 1/4/44", rd_w_v_o, rd_addr_o, rd_data_o); end
    tests_run++; if (wb2_ready_o !== 1'b1) begin tests_failed++; $display("FAIL prio_grant_wb2: got %b want 1", wb2_ready_o); end
    tick();
    wb2_v_i = 0;
    #1;
    tests_run++; if (rd_w_v_o !== 1'b1 || rd_addr_o !== 5'd6 || rd_data_o !== 64'h66) begin tests_failed++; $display("FAIL prio_rd_t3: got %b/%0d/%h want 1/6/66", rd_w_v_o, rd_addr_o, rd_data_o); end
    tick();
    tests_run++; if (rd_w_v_o !== 1'b0 || rd_addr_o !== 5'd6 || rd_data_o !== 64'h66) begin tests_failed++; $display("FAIL prio_idle_hold: got %b/%0d/%h want 0/6/66", rd_w_v_o, rd_addr_o, rd_data_o); end
    tests_run++; if (busy_o !== 32'h0) begin tests_failed++; $display("FAIL prio_busy_clear: got %h want 0", busy_o); end
  endtask

  task automatic test_cfg();
    issue_rd(7); issue_rd(9);
    cfg_w_v_i = 1; cfg_addr_i = 7; cfg_data_i = 64'hDEAD;
    wb0_v_i = 1; wb0_addr_i = 9; wb0_data_i = 64'h99;
    #1;
    tests_run++; if ({wb0_ready_o, wb1_ready_o, wb2_ready_o} !== 3'b000) begin tests_failed++; $display("FAIL cfg_blocks_wb: got %b want 000", {wb0_ready_o, wb1_ready_o, wb2_ready_o}); end
    tick();
    cfg_w_v_i = 0;
    #1;
    tests_run++; if (rd_w_v_o !== 1'b1 || rd_addr_o !== 5'd7 || rd_data_o !== 64'hDEAD) begin tests_failed++; $display("FAIL cfg_rd_port: got %b/%0d/%h want 1/7/dead", rd_w_v_o, rd_addr_o, rd_data_o); end
    tests_run++; if (busy_o !== 32'h0000_0280) begin tests_failed++; $display("FAIL cfg_busy_unchanged: got %h want 00000280", busy_o); end
    tests_run++; if (wb0_ready_o !== 1'b1) begin tests_failed++; $display("FAIL cfg_wb0_after: got %b want 1", wb0_ready_o); end
    tick();
    wb0_v_i = 0;
    #1;
    tests_run++; if (rd_addr_o !== 5'd9 || busy_o !== 32'h0000_0080) begin tests_failed++; $display("FAIL cfg_wb0_done: got %0d/%h want 9/00000080", rd_addr_o, busy_o); end
  endtask

  task automatic test_round_robin();
    int i1, i2;
    logic exp1;
    logic [A-1:0] exp_addr;
    apply_reset();
    for (int r = 10; r <= 18; r++) issue_rd(A'(r));
    i1 = 0; i2 = 0;
    wb1_v_i = 1; wb2_v_i = 1;
    for (int k = 0; k < 8; k++) begin
      wb1_addr_i = A'(10 + 2 * i1); wb1_data_i = D'(10 + 2 * i1);
      wb2_addr_i = A'(11 + 2 * i2); wb2_data_i = D'(11 + 2 * i2);
      exp1 = ((k % 2) == 0);
      exp_addr = exp1 ? wb1_addr_i : wb2_addr_i;
      #1;
      tests_run++; if ({wb1_ready_o, wb2_ready_o} !== {exp1, ~exp1}) begin tests_failed++; $display("FAIL rr_grant_%0d: got %b want %b", k, {wb1_ready_o, wb2_ready_o}, {exp1, ~exp1}); end
      tick();
      if (exp1) i1++; else i2++;
      tests_run++; if (rd_w_v_o !== 1'b1 || rd_addr_o !== exp_addr || rd_data_o !== D'(exp_addr)) begin tests_failed++; $display("FAIL rr_rd_%0d: got %b/%0d/%h want 1/%0d", k, rd_w_v_o, rd_addr_o, rd_data_o, exp_addr); end
    end
    wb1_v_i = 0;
    wb2_addr_i = 18; wb2_data_i = 64'h18;
    #1;
    tests_run++; if (wb2_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rr_lone_wb2: got %b want 1", wb2_ready_o); end
    tick();
    wb2_v_i = 0;
    #1;
    tests_run++; if (rd_addr_o !== 5'd18 || busy_o !== 32'h0) begin tests_failed++; $display("FAIL rr_lone_done: got %0d/%h want 18/0", rd_addr_o, busy_o); end
  endtask

  task automatic test_zero_addr();
    wb0_v_i = 1; wb0_addr_i = 0; wb0_data_i = 64'h123;
    #1;
    tests_run++; if (wb0_ready_o !== 1'b1) begin tests_failed++; $display("FAIL zero_wb0_ready: got %b want 1", wb0_ready_o); end
    tick();
    wb0_v_i = 0;
    #1;
    tests_run++; if (rd_w_v_o !== 1'b0) begin tests_failed++; $display("FAIL zero_no_write: got %b want 0", rd_w_v_o); end
    issue_v_i = 1; issue_rd_w_v_i = 1; issue_rd_addr_i = 0;
    #1;
    tests_run++; if (issue_ready_o !== 1'b1) begin tests_failed++; $display("FAIL zero_issue_ready: got %b want 1", issue_ready_o); end
    tick();
    issue_v_i = 0; issue_rd_w_v_i = 0;
    #1;
    tests_run++; if (busy_o !== 32'h0) begin tests_failed++; $display("FAIL zero_busy: got %h want 0", busy_o); end
  endtask

  task automatic test_reset_mid();
    issue_rd(20);
    wb0_v_i = 1; wb0_addr_i = 20; wb0_data_i = 64'hAB;
    tick();
    wb0_v_i = 0; wb0_addr_i = 0;
    issue_rd_w_v_i = 0;
    #1;
    tests_run++; if (rd_w_v_o !== 1'b1 || rd_addr_o !== 5'd20) begin tests_failed++; $display("FAIL mid_pre_write: got %b/%0d want 1/20", rd_w_v_o, rd_addr_o); end
    issue_rd(21);
    reset_n_i = 0;
    #1;
    tests_run++; if (rd_w_v_o !== 1'b0 || rd_addr_o !== 5'd0 || rd_data_o !== 64'd0) begin tests_failed++; $display("FAIL mid_reset_port: got %b/%0d/%h want 0/0/0", rd_w_v_o, rd_addr_o, rd_data_o); end
    tests_run++; if (busy_o !== 32'h0) begin tests_failed++; $display("FAIL mid_reset_busy: got %h want 0", busy_o); end
    tick(); tick();
    reset_n_i = 1;
    tick();
    tests_run++; if (rd_w_v_o !== 1'b0) begin tests_failed++; $display("FAIL mid_release_no_write: got %b want 0", rd_w_v_o); end
    tests_run++; if (issue_ready_o !== 1'b1) begin tests_failed++; $display("FAIL mid_issue_ready: got %b want 1", issue_ready_o); end
  endtask

  initial begin
    test_reset();
    test_scoreboard();
    test_priority();
    test_cfg();
    test_round_robin();
    test_zero_addr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bp_be_rf_wb_arbiter.md
BP_BE_RF_WB_ARBITER -- requirements
Module: bp_be_rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter reg_addr_width_p, default 5, integer register address width.
REQ-002 The block SHALL have parameter dword_width_p, default 64, register data width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports cfg_w_v_i (in, 1), cfg_addr_i (in, reg_addr_width_p) and cfg_data_i (in, dword_width_p), the config-bus register write.
REQ-006 The block SHALL have ports wb0_v_i (in, 1), wb0_addr_i (in, reg_addr_width_p), wb0_data_i (in, dword_width_p) and wb0_ready_o (out, 1), the fixed-latency pipe writeback.
REQ-007 The block SHALL have ports wb1_* and wb2_*, identical to wb0_*, for the long-latency writebacks (mul/div and memory).
REQ-008 The block SHALL have ports issue_v_i (in, 1), issue_rd_w_v_i (in, 1), issue_rd_addr_i, issue_rs1_addr_i and issue_rs2_addr_i (in, reg_addr_width_p each), and issue_ready_o (out, 1), the issue-side hazard check.
REQ-009 The block SHALL have ports rd_w_v_o (out, 1), rd_addr_o (out, reg_addr_width_p) and rd_data_o (out, dword_width_p), which drive the regfile write port.
REQ-010 The block SHALL have port busy_o, output, 2**reg_addr_width_p, the scoreboard state.

Function
REQ-011 Writeback grant priority SHALL be: cfg_w_v_i first, then wb0, then round-robin between wb1 and wb2.
REQ-012 wbN_ready_o SHALL be combinational and asserted only in the cycle wbN is granted; a transfer occurs when wbN_v_i and wbN_ready_o are both high.
REQ-013 While cfg_w_v_i is high, all wbN_ready_o SHALL be 0.
REQ-014 The round-robin pointer SHALL toggle only on a wb1 or wb2 transfer: after a wb1 transfer wb2 is favoured, and after a wb2 transfer wb1 is favoured.
REQ-015 A lone requester among wb1/wb2 SHALL be granted regardless of the pointer.
REQ-016 The winning address and data SHALL appear on rd_addr_o/rd_data_o with rd_w_v_o=1 exactly one cycle after the transfer (registered output); with no transfer, rd_w_v_o=0 and rd_addr_o/rd_data_o hold their values.
REQ-017 Any transfer with address 0 SHALL be accepted, but rd_w_v_o SHALL stay 0 for it.
REQ-018 Scoreboard: busy[i] SHALL be set on issue acceptance (issue_v_i & issue_ready_o) when issue_rd_w_v_i=1 and issue_rd_addr_i=i≠0.
REQ-019 busy[i] SHALL be cleared on a wb0/wb1/wb2 transfer with address i; a cfg write SHALL NOT alter busy.
REQ-020 issue_ready_o SHALL be 0 when the registered busy bit is set for rs1, rs2, or (when issue_rd_w_v_i=1) rd, and SHALL be 1 otherwise; issue_ready_o SHALL NOT depend on issue_v_i.
REQ-021 The hazard check SHALL use only the registered busy bits; a clear in the current cycle SHALL unblock issue starting the next cycle.
REQ-022 Set and clear of the same index in one cycle SHALL be impossible by REQ-020; should it occur, set SHALL win.
REQ-023 busy[0] SHALL be 0 at all times.
REQ-024 The block SHALL assert (simulation only) if a wb0/wb1/wb2 transfer targets a nonzero index whose busy bit is 0.

Reset
REQ-025 When reset_n_i=0, the block SHALL immediately clear busy, rd_w_v_o, rd_addr_o and rd_data_o, and set the round-robin pointer to favour wb1.
REQ-026 Reset asserted mid-operation SHALL discard any pending registered write; no write SHALL issue on the first edge after deassertion.
REQ-027 The wbN_ready_o and issue_ready_o outputs SHALL be combinational from state and inputs, and SHALL read as 1 for issue when no hazard exists after reset.

Verification
REQ-028 Issue rd=5, rd_w_v=1 -> busy[5]=1 next cycle; issue with rs1=5 -> issue_ready_o=0; wb1 transfer to 5 -> issue_ready_o=1 on the following cycle.
REQ-029 wb0, wb1 and wb2 all valid to regs 3, 4 and 6 -> granted in order wb0, wb1, wb2; rd_w_v_o pulses carry 3, 4, 6 on cycles t+1, t+2, t+3.
REQ-030 cfg_w_v_i=1 to reg 7 with data 0xDEAD while wb0 is valid -> wb0_ready_o=0; rd_addr_o=7, rd_data_o=0xDEAD next cycle; busy unchanged.
REQ-031 wb1 and wb2 continuously valid -> grants alternate wb1, wb2, wb1, wb2 with no starvation.
REQ-032 wb0 transfer to addr 0 -> rd_w_v_o stays 0; issue rd=0, rd_w_v=1 -> busy unchanged.
REQ-033 Assert reset_n_i=0 one cycle after a transfer -> rd_w_v_o drops immediately, busy_o=0, and no write issues after release.
